// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for a 32-bit MIPS datapath.
// Steps one instruction at a time through fetch / decode / execute / memory /
// writeback. It shares one ALU and one memory port, and tolerates wait states
// on the memory port, with a timeout abort.
//
// Ports:
//   clk, rst_n          system clock (rising edge), async active-low reset
//   opcode, funct       instruction register fields (valid from DECODE on)
//   mem_ready           memory completed the current request this cycle
//   mem_req, mem_we     memory request / write qualifier
//   iord                0 = PC addresses memory, 1 = ALUOut
//   ir_write, pc_write  IR latch and PC load strobes
//   reg_write           register file write strobe
//   mem_to_reg, reg_dst writeback data / destination selects
//   alu_src_a/b         ALU operand selects
//   alu_control         ALU operation
//   illegal_op, bus_err one-cycle error pulses
//   instr_count         retired instruction counter (wraps)
//   state_o             current state encoding
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE | classify opcode/funct, flag illegal encodings
// MEMADR | compute base + offset for lw/sw
// MEMRD  | data read request (lw)
// MEMWB  | write loaded data to rt
// MEMWR  | data write request (sw), retires on mem_ready
// EXEC_R | R-type ALU operation
// EXEC_I | immediate ALU operation
// ALUWB  | write ALU result to rd/rt
module multicycle_control_fsm #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 iord,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [3:0]           alu_control,
  output logic                 illegal_op,
  output logic                 bus_err,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic [3:0]           state_o
);

  localparam int WAIT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t                state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic in_mem_state;
  logic mem_done;
  logic mem_abort;
  logic funct_ok;
  logic [3:0] r_alu_op;

  // R-type funct decode: legality and ALU operation together
  always_comb begin
    funct_ok = 1'b1;
    r_alu_op = 4'b0000;
    unique case (funct)
      6'b100000: r_alu_op = 4'b0100;
      6'b100010: r_alu_op = 4'b0101;
      6'b100100: r_alu_op = 4'b1010;
      6'b100101: r_alu_op = 4'b1000;
      6'b100110: r_alu_op = 4'b1011;
      6'b011001: r_alu_op = 4'b0110;
      6'b000000: r_alu_op = 4'b1100;
      6'b000010: r_alu_op = 4'b1101;
      6'b000011: r_alu_op = 4'b1110;
      default:   funct_ok = 1'b0;
    endcase
  end

  assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign mem_done     = in_mem_state && mem_ready;
  // mem_ready on the limit cycle wins over the abort
  assign mem_abort    = in_mem_state && !mem_ready && (wait_q == WAIT_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  // Next-state, wait counter and retire counter
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    // Cleared outside memory states and on completion/abort, so every
    // memory-state entry (including FETCH re-entry after abort) starts at 0.
    wait_d  = '0;
    if (in_mem_state && !mem_done && !mem_abort) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    unique case (state_q)
      S_FETCH: begin
        if (mem_done) state_d = S_DECODE;
        else if (mem_abort) state_d = S_FETCH;
      end
      S_DECODE: begin
        state_d = S_FETCH;
        if (opcode == OP_RTYPE) begin
          if (funct_ok) state_d = S_EXEC_R;
        end else if (opcode == OP_ADDI || opcode == OP_ANDI ||
                     opcode == OP_ORI  || opcode == OP_XORI) begin
          state_d = S_EXEC_I;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = S_MEMADR;
        end
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_done) state_d = S_MEMWB;
        else if (mem_abort) state_d = S_FETCH;
      end
      S_MEMWB: begin
        count_d = count_q + CNT_WIDTH'(1);
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        if (mem_done) begin
          count_d = count_q + CNT_WIDTH'(1);
          state_d = S_FETCH;
        end else if (mem_abort) begin
          state_d = S_FETCH;
        end
      end
      S_EXEC_R: state_d = S_ALUWB;
      S_EXEC_I: state_d = S_ALUWB;
      S_ALUWB: begin
        count_d = count_q + CNT_WIDTH'(1);
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs; forced low while reset is asserted, independent of the clock
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 4'b0000;
    illegal_op  = 1'b0;
    bus_err     = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        S_FETCH: begin
          mem_req     = !mem_abort;
          alu_src_b   = 2'b01;
          alu_control = 4'b0100;
          ir_write    = mem_done;
          pc_write    = mem_done;
          bus_err     = mem_abort;
        end
        S_DECODE: begin
          illegal_op = (state_d == S_FETCH);
        end
        S_MEMADR: begin
          alu_src_a   = 1'b1;
          alu_src_b   = 2'b10;
          alu_control = 4'b0100;
        end
        S_MEMRD: begin
          mem_req = !mem_abort;
          iord    = 1'b1;
          bus_err = mem_abort;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_req = !mem_abort;
          mem_we  = !mem_abort;
          iord    = 1'b1;
          bus_err = mem_abort;
        end
        S_EXEC_R: begin
          alu_src_a   = 1'b1;
          alu_control = r_alu_op;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          unique case (opcode)
            OP_ANDI: alu_control = 4'b1010;
            OP_ORI:  alu_control = 4'b1000;
            OP_XORI: alu_control = 4'b1011;
            default: alu_control = 4'b0100;
          endcase
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = (opcode == OP_RTYPE);
        end
        default: ;
      endcase
    end
  end

  assign instr_count = count_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write, reg_write;
  logic        mem_to_reg, reg_dst, alu_src_a;
  logic [1:0]  alu_src_b;
  logic [3:0]  alu_control;
  logic        illegal_op, bus_err;
  logic [31:0] instr_count;
  logic [3:0]  state_o;

  int checks = 0;
  int failures = 0;

  multicycle_control_fsm #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .illegal_op(illegal_op),
    .bus_err(bus_err), .instr_count(instr_count), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; sample 2 time units after the rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b000000; funct = 6'b100000;
    #2;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_ir_write", 32'(ir_write), 0);
    chk("rst_alu_ctl", 32'(alu_control), 0);
    chk("rst_alu_src_b", 32'(alu_src_b), 0);
    chk("rst_count", instr_count, 0);
    #10;
    rst_n = 1'b1;
    #1;
    // add, zero-wait
    chk("add_fetch_state", 32'(state_o), 0);
    chk("add_fetch_req", 32'(mem_req), 1);
    chk("add_fetch_irw", 32'(ir_write), 1);
    chk("add_fetch_pcw", 32'(pc_write), 1);
    chk("add_fetch_srcb", 32'(alu_src_b), 1);
    chk("add_fetch_alu", 32'(alu_control), 4'b0100);
    tick();
    chk("add_decode_state", 32'(state_o), 1);
    chk("add_decode_req", 32'(mem_req), 0);
    chk("add_decode_ill", 32'(illegal_op), 0);
    tick();
    chk("add_exec_state", 32'(state_o), 6);
    chk("add_exec_alu", 32'(alu_control), 4'b0100);
    chk("add_exec_srca", 32'(alu_src_a), 1);
    chk("add_exec_srcb", 32'(alu_src_b), 0);
    tick();
    chk("add_wb_state", 32'(state_o), 8);
    chk("add_wb_regw", 32'(reg_write), 1);
    chk("add_wb_regdst", 32'(reg_dst), 1);
    chk("add_wb_m2r", 32'(mem_to_reg), 0);
    tick();
    chk("add_done_state", 32'(state_o), 0);
    chk("add_done_count", instr_count, 1);

    // lw with 3 wait cycles in MEMRD
    opcode = 6'b100011;
    tick();
    chk("lw_decode_state", 32'(state_o), 1);
    tick();
    chk("lw_memadr_state", 32'(state_o), 2);
    chk("lw_memadr_srcb", 32'(alu_src_b), 2);
    chk("lw_memadr_alu", 32'(alu_control), 4'b0100);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lw_memrd_state", 32'(state_o), 3);
      chk("lw_memrd_req", 32'(mem_req), 1);
      chk("lw_memrd_iord", 32'(iord), 1);
      chk("lw_memrd_buserr", 32'(bus_err), 0);
    end
    tick();
    mem_ready = 1'b1;
    #1;
    chk("lw_memrd4_state", 32'(state_o), 3);
    chk("lw_memrd4_we", 32'(mem_we), 0);
    chk("lw_memrd4_buserr", 32'(bus_err), 0);
    tick();
    chk("lw_memwb_state", 32'(state_o), 4);
    chk("lw_memwb_regw", 32'(reg_write), 1);
    chk("lw_memwb_m2r", 32'(mem_to_reg), 1);
    chk("lw_memwb_regdst", 32'(reg_dst), 0);
    chk("lw_memwb_count", instr_count, 1);
    tick();
    chk("lw_done_state", 32'(state_o), 0);
    chk("lw_done_count", instr_count, 2);

    // sw zero-wait
    opcode = 6'b101011;
    tick();
    tick();
    chk("sw_memadr_state", 32'(state_o), 2);
    tick();
    chk("sw_memwr_state", 32'(state_o), 5);
    chk("sw_memwr_we", 32'(mem_we), 1);
    chk("sw_memwr_req", 32'(mem_req), 1);
    chk("sw_memwr_regw", 32'(reg_write), 0);
    tick();
    chk("sw_done_state", 32'(state_o), 0);
    chk("sw_done_count", instr_count, 3);
    chk("sw_done_we", 32'(mem_we), 0);

    // illegal opcode 000100
    opcode = 6'b000100;
    tick();
    chk("ill_op_state", 32'(state_o), 1);
    chk("ill_op_pulse", 32'(illegal_op), 1);
    chk("ill_op_regw", 32'(reg_write), 0);
    tick();
    chk("ill_op_next", 32'(state_o), 0);
    chk("ill_op_clear", 32'(illegal_op), 0);
    chk("ill_op_count", instr_count, 3);

    // illegal R-type funct 101010
    opcode = 6'b000000; funct = 6'b101010;
    tick();
    chk("ill_fn_pulse", 32'(illegal_op), 1);
    tick();
    chk("ill_fn_next", 32'(state_o), 0);
    chk("ill_fn_count", instr_count, 3);

    // FETCH timeout with limit 4
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("to_wait_req", 32'(mem_req), 1);
      chk("to_wait_buserr", 32'(bus_err), 0);
      chk("to_wait_pcw", 32'(pc_write), 0);
      chk("to_wait_irw", 32'(ir_write), 0);
      tick();
    end
    chk("to_abort_buserr", 32'(bus_err), 1);
    chk("to_abort_req", 32'(mem_req), 0);
    chk("to_abort_pcw", 32'(pc_write), 0);
    chk("to_abort_irw", 32'(ir_write), 0);
    chk("to_abort_state", 32'(state_o), 0);
    tick();
    chk("to_refetch_state", 32'(state_o), 0);
    chk("to_refetch_req", 32'(mem_req), 1);
    chk("to_refetch_buserr", 32'(bus_err), 0);
    chk("to_count", instr_count, 3);

    // ori, reset during EXEC_I
    mem_ready = 1'b1; opcode = 6'b001101;
    tick();
    tick();
    chk("ori_exec_state", 32'(state_o), 7);
    chk("ori_exec_alu", 32'(alu_control), 4'b1000);
    chk("ori_exec_srcb", 32'(alu_src_b), 2);
    rst_n = 1'b0;
    #1;
    chk("ori_rst_alu", 32'(alu_control), 0);
    chk("ori_rst_srca", 32'(alu_src_a), 0);
    chk("ori_rst_srcb", 32'(alu_src_b), 0);
    chk("ori_rst_state", 32'(state_o), 0);
    chk("ori_rst_count", instr_count, 0);
    #4;
    rst_n = 1'b1;
    #1;
    chk("ori_rel_state", 32'(state_o), 0);
    chk("ori_rel_count", instr_count, 0);
    chk("ori_rel_req", 32'(mem_req), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle sequencer for the 32-bit MIPS datapath. It steps one instruction at a time through fetch, decode, execute, memory and writeback, sharing one ALU and one memory port.
- It drives the datapath mux selects and write strobes each cycle, and handshakes with a memory port that may insert wait states.
- It sits between the instruction register (opcode/funct inputs) and the shared register file, ALU and memory.

Parameters:
TIMEOUT_CYCLES, 255, max cycles a memory request may wait for mem_ready before abort (>=1)
CNT_WIDTH, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
mem_ready  in  1  memory has completed the current request this cycle
mem_req  out  1  memory request, held until mem_ready or timeout
mem_we  out  1  request is a write
iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
ir_write  out  1  latch instruction register
pc_write  out  1  load PC with ALU result
reg_write  out  1  register file write strobe
mem_to_reg  out  1  writeback data: 1 = memory data register, 0 = ALUOut
reg_dst  out  1  1 = rd, 0 = rt
alu_src_a  out  1  0 = PC, 1 = register A
alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate
alu_control  out  4  ALU operation
illegal_op  out  1  one-cycle pulse: unsupported opcode/funct
bus_err  out  1  one-cycle pulse: memory timeout
instr_count  out  CNT_WIDTH  retired instruction count
state_o  out  4  current state encoding (debug)

Behaviour:
- Reset (async, rst_n=0): state=FETCH; wait counter and instr_count cleared to 0. While rst_n=0 every strobe, mem_req, illegal_op and bus_err are 0, alu_control=0000, all selects are 0.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, EXEC_I=7, ALUWB=8. Unused codes go to FETCH.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=0100 (PC+4).
  - ir_write and pc_write are asserted only in the cycle mem_ready=1, then the FSM moves to DECODE.
  - Otherwise it stays in FETCH.
- DECODE: one cycle; all strobes 0. Next state by opcode:
  - 000000 -> EXEC_R if funct is supported, else illegal
  - 001000, 001100, 001101, 001110 -> EXEC_I
  - 100011, 101011 -> MEMADR
  - any other opcode -> illegal
  - Illegal: illegal_op=1 for that cycle, next state FETCH, no write occurs.
- EXEC_R: alu_src_a=1, alu_src_b=00. alu_control by funct:
  - 100000 -> 0100, 100010 -> 0101, 100100 -> 1010, 100101 -> 1000, 100110 -> 1011
  - 011001 -> 0110, 000000 -> 1100, 000010 -> 1101, 000011 -> 1110
  - Next state ALUWB.
- EXEC_I: alu_src_a=1, alu_src_b=10. alu_control: addi 0100, andi 1010, ori 1000, xori 1011. Next state ALUWB.
- ALUWB: reg_write=1, mem_to_reg=0, reg_dst=1 if opcode=000000 else 0. Increment instr_count; next state FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_control=0100. Next state MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req=1, iord=1, mem_we=0. On mem_ready -> MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Increment instr_count; next state FETCH.
- MEMWR: mem_req=1, iord=1, mem_we=1. On mem_ready: increment instr_count, next state FETCH.
- Memory handshake:
  - mem_req rises on entry to FETCH/MEMRD/MEMWR and stays constant until mem_ready or abort.
  - mem_ready outside those states is ignored.
  - Zero-wait memory returns mem_ready in the first request cycle.
- Timeout:
  - The wait counter clears on entry to each memory state and increments each request cycle with mem_ready=0.
  - When it reaches TIMEOUT_CYCLES with mem_ready still 0: bus_err=1 for one cycle, mem_req drops, next state FETCH, no pc_write/ir_write/reg_write.
  - A timeout in FETCH therefore re-fetches the same PC.
  - mem_ready=1 in the same cycle the limit is reached counts as success, not timeout.
- Latency with zero-wait memory: R/I-type 4 cycles, lw 5, sw 4, illegal 2.
- instr_count wraps modulo 2^CNT_WIDTH.
- Reset mid-instruction: the FSM returns to FETCH immediately and any in-flight request is abandoned; strobes are 0 asynchronously.

Test Plan:
- Reset release, mem_ready tied 1, IR = add (000000/100000): state sequence 0,1,6,8,0; EXEC_R alu_control=0100; ALUWB reg_write=1, reg_dst=1; instr_count=1.
- lw (100011), mem_ready low 3 cycles in MEMRD: MEMRD held 4 cycles with mem_req=1, iord=1; then MEMWB with mem_to_reg=1, reg_dst=0; 5+3 cycles total; no bus_err.
- sw (101011), zero-wait: MEMWR mem_we=1 for one cycle, reg_write never 1, instr_count increments on mem_ready.
- Opcode 000100, then R-type funct 101010: illegal_op pulses once in DECODE each time; next state FETCH; instr_count unchanged.
- TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH: bus_err pulse after 4 wait cycles, pc_write/ir_write never asserted, FETCH re-entered with mem_req=1.
- ori (001101) then rst_n pulsed low during EXEC_I: outputs go to 0 immediately; after release state=FETCH and instr_count=0.
